// File: rtl/ram_sx2_pkg.sv
// Shared constants and helpers for ram_sx2: byte-lane count, channel limit, one-hot to index.
// Pure package; no logic or timing of its own.
package ram_sx2_pkg;

  localparam int CChCntMax = 4;
  localparam int CIdxLen   = 2;

  function automatic int be_len(input int data_len);
    return data_len / 8;
  endfunction

  function automatic logic [CIdxLen-1:0] onehot_to_idx(input logic [CChCntMax-1:0] oh);
    logic [CIdxLen-1:0] idx;
    idx = '0;
    for (int i = 0; i < CChCntMax; i++) begin
      if (oh[i]) idx = idx | CIdxLen'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_sx2_arb.sv
// Channel arbiter: one-hot grant plus index, combinational in the request cycle.
// Fixed priority (lowest first) by default; round-robin pointer only when RAM_SX2_RR_EN is defined.
// Losers see no grant and simply keep requesting.
module ram_sx2_arb
  import ram_sx2_pkg::*;
#(
  parameter int CChCnt = 2
) (
`ifdef RAM_SX2_RR_EN
  input  logic               AClkH,
  input  logic               AResetHN,
`endif
  input  logic               AClkHEn,
  input  logic [CChCnt-1:0]  AReq,
  output logic [CChCnt-1:0]  grant,
  output logic [CIdxLen-1:0] grant_idx
);

  logic found;

  assign grant_idx = onehot_to_idx(CChCntMax'(grant));

`ifdef RAM_SX2_RR_EN
  logic [CIdxLen-1:0] ptr;

  // Two passes: channels above the last winner first, then wrap to the rest.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (AClkHEn) begin
      for (int j = 0; j < CChCnt; j++) begin
        if (!found && AReq[j] && (CIdxLen'(j) > ptr)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int j = 0; j < CChCnt; j++) begin
        if (!found && AReq[j] && (CIdxLen'(j) <= ptr)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      ptr <= CIdxLen'(CChCnt - 1);
    end else if (AClkHEn && |grant) begin
      ptr <= grant_idx;
    end
  end
`else
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (AClkHEn) begin
      for (int j = 0; j < CChCnt; j++) begin
        if (!found && AReq[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/ram_sx2.sv
// Multi-channel single-port RAM with byte-enable writes; read data one enabled cycle after grant.
// Grant is combinational (AAck); ungranted channels hold their request. Macro RAM_SX2_RR_EN selects round-robin.
module ram_sx2
  import ram_sx2_pkg::*;
#(
  parameter int  CAddrLen = 13,
  parameter int  CDataLen = 128,
  parameter int  CChCnt   = 2,
  localparam int CBeLen   = be_len(CDataLen)
) (
  input  logic                       AClkH,
  input  logic                       AResetHN,
  input  logic                       AClkHEn,
  input  logic [CChCnt-1:0]          AReq,
  input  logic [CChCnt-1:0]          AWr,
  input  logic [CChCnt*CAddrLen-1:0] AAddr,
  input  logic [CChCnt*CDataLen-1:0] AMosi,
  input  logic [CChCnt*CBeLen-1:0]   ABe,
  output logic [CChCnt-1:0]          AAck,
  output logic [CDataLen-1:0]        AMiso,
  output logic [CChCnt-1:0]          AMisoVld
);

  if (CChCnt < 1 || CChCnt > CChCntMax) begin : g_bad_ch_cnt
    $error("ram_sx2: CChCnt out of range");
  end

  logic [CIdxLen-1:0]  grant_idx;
  logic                any_gnt;
  logic                sel_wr;
  logic [CAddrLen-1:0] sel_addr;
  logic [CDataLen-1:0] sel_dat;
  logic [CBeLen-1:0]   sel_be;
  logic [CAddrLen-1:0] addr_q;
  logic [CChCnt-1:0]   vld_q;
  logic [CDataLen-1:0] mem [2**CAddrLen];

  ram_sx2_arb #(.CChCnt(CChCnt)) u_arb (
`ifdef RAM_SX2_RR_EN
    .AClkH     (AClkH),
    .AResetHN  (AResetHN),
`endif
    .AClkHEn   (AClkHEn),
    .AReq      (AReq),
    .grant     (AAck),
    .grant_idx (grant_idx)
  );

  assign any_gnt = |AAck;

  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_dat  = '0;
    sel_be   = '0;
    for (int j = 0; j < CChCnt; j++) begin
      if (CIdxLen'(j) == grant_idx) begin
        sel_wr   = AWr[j];
        sel_addr = AAddr[j*CAddrLen +: CAddrLen];
        sel_dat  = AMosi[j*CDataLen +: CDataLen];
        sel_be   = ABe[j*CBeLen +: CBeLen];
      end
    end
  end

  // Memory is deliberately outside reset: contents survive AResetHN.
  always_ff @(posedge AClkH) begin
    if (AClkHEn && any_gnt && sel_wr) begin
      for (int b = 0; b < CBeLen; b++) begin
        if (sel_be[b]) mem[sel_addr][b*8 +: 8] <= sel_dat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      addr_q <= '0;
      vld_q  <= '0;
    end else if (AClkHEn) begin
      if (any_gnt) begin
        addr_q <= sel_addr;
        vld_q  <= sel_wr ? '0 : AAck;
      end else begin
        vld_q  <= '0;
      end
    end
  end

  // A pending read is only presented in an enabled cycle; the register itself holds across stalls.
  assign AMisoVld = vld_q & {CChCnt{AClkHEn}};
  assign AMiso    = (|AMisoVld) ? mem[addr_q] : '0;

endmodule

// File: tb/tb_ram_sx2.sv
// Directed bench for ram_sx2 (2 channels, default widths); expected values are hand-computed constants.
module tb_ram_sx2;

  localparam int AW = 13;
  localparam int DW = 128;
  localparam int CH = 2;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [CH-1:0]     areq;
  logic [CH-1:0]     awr;
  logic [CH*AW-1:0]  aaddr;
  logic [CH*DW-1:0]  amosi;
  logic [CH*BW-1:0]  abe;
  logic [CH-1:0]     aack;
  logic [DW-1:0]     amiso;
  logic [CH-1:0]     amisovld;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [DW-1:0] DA5  = {16{8'hA5}};
  localparam logic [DW-1:0] DALT = {8{16'h00FF}};
  localparam logic [DW-1:0] DFF  = {16{8'hFF}};

  logic [CH-1:0] exp_ack [4];

  ram_sx2 #(.CAddrLen(AW), .CDataLen(DW), .CChCnt(CH)) dut (
    .AClkH    (clk),
    .AResetHN (rst_n),
    .AClkHEn  (en),
    .AReq     (areq),
    .AWr      (awr),
    .AAddr    (aaddr),
    .AMosi    (amosi),
    .ABe      (abe),
    .AAck     (aack),
    .AMiso    (amiso),
    .AMisoVld (amisovld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input logic req, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] dat, input logic [BW-1:0] be);
    areq[ch]             = req;
    awr[ch]              = wr;
    aaddr[ch*AW +: AW]   = addr;
    amosi[ch*DW +: DW]   = dat;
    abe[ch*BW +: BW]     = be;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    areq  = '0;
    awr   = '0;
    aaddr = '0;
    amosi = '0;
    abe   = '0;
`ifdef RAM_SX2_RR_EN
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_ack = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_vld", DW'(amisovld), '0);
    check("rst_miso", amiso, '0);
    check("rst_ack", DW'(aack), '0);

    // Scenario 1: full write then read of addr 5 on ch0
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b1, 13'd5, DA5, '1);
    #1 check("s1_wr_ack", DW'(aack), DW'(2'b01));
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 13'd5, '0, '0);
    #1 check("s1_rd_ack", DW'(aack), DW'(2'b01));
    check("s1_no_vld_after_wr", DW'(amisovld), '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    #1 check("s1_vld", DW'(amisovld), DW'(2'b01));
    check("s1_data", amiso, DA5);
    check("s1_idle_ack", DW'(aack), '0);

    // Scenario 2: byte-enable write on ch1, plus an all-zero ABe write
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 13'd7, '0, '1);
    #1 check("s2_clr_ack", DW'(aack), DW'(2'b10));
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 13'd7, DFF, 16'h5555);
    #1 check("s2_be_ack", DW'(aack), DW'(2'b10));
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 13'd7, '0, '0);
    #1 check("s2_rd_ack", DW'(aack), DW'(2'b10));
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 13'd7, {8{16'h1234}}, '0);
    #1 check("s2_be0_ack", DW'(aack), DW'(2'b10));
    check("s2_vld", DW'(amisovld), DW'(2'b10));
    check("s2_data", amiso, DALT);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 13'd7, '0, '0);
    #1 check("s2_rd2_ack", DW'(aack), DW'(2'b10));
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    #1 check("s2_be0_vld", DW'(amisovld), DW'(2'b10));
    check("s2_be0_data", amiso, DALT);

    // Scenario 3: both channels read continuously for 4 cycles
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 13'd5, '0, '0);
      drive(1, 1'b1, 1'b0, 13'd7, '0, '0);
      #1 check($sformatf("s3_ack%0d", k), DW'(aack), DW'(exp_ack[k]));
      if (k > 0) begin
        check($sformatf("s3_vld%0d", k), DW'(amisovld), DW'(exp_ack[k-1]));
        check($sformatf("s3_data%0d", k), amiso, (exp_ack[k-1] == 2'b01) ? DA5 : DALT);
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    #1 check("s3_vld_last", DW'(amisovld), DW'(exp_ack[3]));
    check("s3_data_last", amiso, (exp_ack[3] == 2'b01) ? DA5 : DALT);

    // Scenario 4: read granted, then three disabled cycles
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 13'd5, '0, '0);
    #1 check("s4_ack", DW'(aack), DW'(2'b01));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      en = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b1, 1'b0, 13'd7, '0, '0);
      #1 check($sformatf("s4_dis_ack%0d", k), DW'(aack), '0);
      check($sformatf("s4_dis_vld%0d", k), DW'(amisovld), '0);
      check($sformatf("s4_dis_miso%0d", k), amiso, '0);
    end
    @(negedge clk);
    en = 1'b1;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    #1 check("s4_vld", DW'(amisovld), DW'(2'b01));
    check("s4_data", amiso, DA5);
    check("s4_idle_ack", DW'(aack), '0);
    @(negedge clk);
    #1 check("s4_vld_once", DW'(amisovld), '0);
    check("s4_miso_zero", amiso, '0);

    // Scenario 5: reset pulse while a read is in flight
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 13'd7, '0, '0);
    #1 check("s5_ack", DW'(aack), DW'(2'b01));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    #1 check("s5_rst_vld", DW'(amisovld), '0);
    check("s5_rst_miso", amiso, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("s5_rel_vld", DW'(amisovld), '0);
    check("s5_rel_miso", amiso, '0);
    @(negedge clk);
    #1 check("s5_post_vld", DW'(amisovld), '0);
    check("s5_post_miso", amiso, '0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 13'd5, '0, '0);
    drive(1, 1'b1, 1'b0, 13'd7, '0, '0);
    #1 check("s5_both_ack", DW'(aack), DW'(2'b01));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    #1 check("s5_ch1_ack", DW'(aack), DW'(2'b10));
    check("s5_vld0", DW'(amisovld), DW'(2'b01));
    check("s5_data0", amiso, DA5);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    #1 check("s5_vld1", DW'(amisovld), DW'(2'b10));
    check("s5_data1", amiso, DALT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sx2.md
RAM_SX2 -- requirements
Module: ram_sx2

Interface
REQ-001 The block SHALL have parameter CAddrLen, default 13, meaning the word address width (depth = 2^CAddrLen).
REQ-002 The block SHALL have parameter CDataLen, default 128, meaning the word width; a multiple of 8.
REQ-003 The block SHALL have parameter CChCnt, default 2, meaning the number of requester channels; legal range 1..4.
REQ-004 Ports SHALL be as listed below; channel-indexed buses are flattened with channel 0 in the LSBs, and CBeLen = CDataLen/8.
- AClkH  in  1  the single clock.
- AResetHN  in  1  reset, asynchronous, active-low.
- AClkHEn  in  1  clock enable; all state advances only when it is 1.
- AReq  in  CChCnt  access request per channel, held until acked.
- AWr  in  CChCnt  1 = write, 0 = read, per channel.
- AAddr  in  CChCnt*CAddrLen  word address per channel.
- AMosi  in  CChCnt*CDataLen  write data per channel.
- ABe  in  CChCnt*CBeLen  byte enables per channel (writes only).
- AAck  out  CChCnt  one-hot grant, combinational, same cycle as the access.
- AMiso  out  CDataLen  read data.
- AMisoVld  out  CChCnt  one-hot read-data-valid, qualifies AMiso for that channel.

Function
REQ-005 Each cycle with AClkHEn=1 and at least one AReq bit set, the arbiter SHALL grant exactly one requesting channel; AAck SHALL have that bit set and no other bit.
REQ-006 AAck SHALL be all zero when AClkHEn=0 or AReq=0.
REQ-007 A granted write SHALL update, at that clock edge, only the bytes of the addressed word whose ABe bit is 1; ABe=0 SHALL leave the word unchanged and still be acked.
REQ-008 A granted read SHALL present the word on AMiso on the next enabled cycle, with AMisoVld set to the granted channel's bit for exactly that cycle; read latency is 1 enabled cycle.
REQ-009 When AMisoVld is 0, AMiso SHALL be all zero.
REQ-010 A read granted in the cycle after a write to the same address SHALL return the newly written data.
REQ-011 When no access is granted, the memory address register SHALL hold its previous value; no write SHALL occur.
REQ-012 With AClkHEn=0, all registers including AMiso/AMisoVld SHALL hold, and no write SHALL occur.
REQ-013 A channel not granted SHALL see AAck=0 and MAY change nothing; its request stays pending with no loss.
REQ-014 For CChCnt=1, the arbiter SHALL reduce to AAck = AReq & AClkHEn.

Reset
REQ-015 While AResetHN=0, AMiso SHALL be 0, AMisoVld 0, the held address 0, and the arbitration pointer CChCnt-1, so channel 0 wins first.
REQ-016 Reset SHALL NOT clear the memory contents; the contents after power-up are undefined.
REQ-017 A read in flight when reset asserts SHALL be discarded, and no AMisoVld SHALL follow reset release.

Configuration
REQ-018 With RAM_SX2_RR_EN defined, arbitration SHALL be round-robin: priority starts at (last granted + 1) mod CChCnt, and the pointer updates only on a grant.
REQ-019 Without RAM_SX2_RR_EN, arbitration SHALL be fixed priority, lowest index first, and the pointer register SHALL be absent.

Structure
REQ-020 Package ram_sx2_pkg SHALL hold the CBeLen derivation function, the CChCnt range limit, and the one-hot/index conversion function.
REQ-021 Arbitration SHALL be in sub-module ram_sx2_arb, with inputs AReq and AClkHEn and outputs the one-hot grant and the grant index; the memory array SHALL be inferred inline.

Verification
REQ-022 Scenario 1: reset release, ch0 writes 0xA5 to all bytes of addr 5 (ABe all ones), next cycle ch0 reads addr 5 -> AAck[0] on both cycles, and on the following cycle AMisoVld=01 with AMiso = all 0xA5 bytes.
REQ-023 Scenario 2: addr 7 holds all 0x00, ch1 writes all 0xFF with ABe=...0101, then reads addr 7 -> AMiso bytes alternate 0xFF/0x00 from byte 0.
REQ-024 Scenario 3: ch0 and ch1 request continuously (reads) for 4 cycles -> with RAM_SX2_RR_EN, AAck = 01,10,01,10; without it, AAck = 01 on all 4 cycles.
REQ-025 Scenario 4: a read is granted, then AClkHEn=0 for 3 cycles, then 1 -> AMisoVld stays 0, then rises for one enabled cycle with the correct data; no AAck while AClkHEn=0.
REQ-026 Scenario 5: AResetHN pulsed low the cycle after a read grant -> AMisoVld and AMiso stay 0 after release; previously written memory data still reads back correctly.
